vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Display timing generator feeding the VGA compositor, sprite modules and the background image RAM.
// - Produces H/V sync and the visible-area flag.
// - Produces raw pixel row/column counts for sprite hit tests.
// - Produces a linear pixel address for the background frame buffer.
// - Default timing is 640x480@60 at a 25.175 MHz pixel rate.
// - An optional clock-enable lets the block run from a faster vga_clk_i.
// PARAMETERS
// - H_DISP    640  visible pixels per line
// - H_FP      16   horizontal front porch (pixels)
// - H_SYNC    96   horizontal sync width (pixels)
// - H_BP      48   horizontal back porch (pixels); H_TOTAL = sum of H_* = 800
// - V_DISP    480  visible lines per frame
// - V_FP      10   vertical front porch (lines)
// - V_SYNC    2    vertical sync width (lines)
// - V_BP      33   vertical back porch (lines); V_TOTAL = sum of V_* = 525
// - SYNC_POL  0    active level of horiz_sync/vert_sync (0 = active-low)
// - ADDR_W    19   width of pix_num; must hold H_DISP*V_DISP-1
// PORTS
// - vga_clk_i     in   1       pixel-domain clock
// - vga_rst_i     in   1       synchronous, active-low reset
// - pix_ce_i      in   1       pixel clock enable; tie 1 when vga_clk_i is the pixel clock
// - horiz_sync    out  1       horizontal sync, level per SYNC_POL
// - vert_sync     out  1       vertical sync, level per SYNC_POL
// - video_on      out  1       1 while (col,row) lies inside the visible area
// - pixel_column  out  12      horizontal count, 0..H_TOTAL-1
// - pixel_row     out  12      vertical count, 0..V_TOTAL-1
// - pix_num       out  ADDR_W  linear frame-buffer address, row*H_DISP+col
// - frame_start   out  1       one-cycle pulse when (col,row) = (0,0)
// BEHAVIOUR
// - Reset: vga_rst_i=0 at a clock edge forces, at that edge:
//   - counters = 0, pixel_column = 0, pixel_row = 0, pix_num = 0
//   - video_on = 0, frame_start = 0
//   - syncs at the inactive level (~SYNC_POL)
//   - Reset overrides pix_ce_i.
//   - Reset asserted mid-frame truncates the frame; there is no partial-frame recovery.
// - Counters (h_cnt, v_cnt):
//   - Advance only on edges with pix_ce_i=1; otherwise every register holds.
//   - h_cnt wraps H_TOTAL-1 -> 0. v_cnt increments only on that wrap.
//   - v_cnt wraps V_TOTAL-1 -> 0 when h_cnt wraps at the same time.
// - Outputs:
//   - All outputs are registered, one enabled cycle behind the counters.
//   - Output state after enabled edge k describes counter value k-1.
//   - First enabled edge after reset release: counters = (1,0); outputs show (0,0) with video_on=1 and frame_start=1.
// - Decode, all in counter units:
//   - video_on  = (h < H_DISP) && (v < V_DISP)
//   - hsync active for H_DISP+H_FP <= h < H_DISP+H_FP+H_SYNC
//   - vsync active for V_DISP+V_FP <= v < V_DISP+V_FP+V_SYNC; vsync changes only on line boundaries
// - pix_num:
//   - Incrementing counter, not a multiplier.
//   - Cleared to 0 at (0,0); +1 per visible pixel; holds outside the visible area.
//   - Last visible pixel of a frame = H_DISP*V_DISP-1 (307199); no wrap within a frame.
// - frame_start: exactly one enabled-cycle pulse per frame, coincident with output (0,0).
// - pix_ce_i toggling does not change sequence, only pacing. Outputs are stable while pix_ce_i=0.
// CONFIGURATION
// - VGA_TIMING_PREFETCH_EN defined:
//   - pix_num leads the other outputs by one enabled cycle: it presents the address of the NEXT pixel.
//   - This offsets the 1-cycle read latency of image_ram, so its data aligns with video_on/row/column.
//   - pix_num = 0 during the cycle before (0,0), i.e. at output (H_TOTAL-1, V_TOTAL-1) and at reset.
// - VGA_TIMING_PREFETCH_EN undefined: pix_num is aligned with pixel_column/pixel_row as described above.
// TESTING
// - Reset release, pix_ce_i=1, default params -> after 1st edge outputs (0,0), video_on=1, frame_start=1, pix_num=0.
// - Run a full line -> video_on high 640 cycles; hsync low for columns 656..751; pixel_column wraps 799->0 and pixel_row 0->1.
// - Run a full frame -> vsync low on rows 490..491 only; pix_num reaches 307199 at (639,479) then holds; frame_start period = 420000 cycles.
// - pix_ce_i pattern 1,0,0,0 repeating -> identical output sequence to a 4x-slowed clock; outputs frozen while pix_ce_i=0.
// - Assert vga_rst_i=0 at (300,200) for 1 cycle -> next outputs are reset values, then restart from (0,0) with frame_start=1.
// - Prefetch build -> pix_num = 1 while pixel_column=0,row=0; pix_num = 0 while at (799,524).

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA display timing generator: sync, visible flag, raw row/column and linear frame-buffer address.
// Optional build macro VGA_TIMING_PREFETCH_EN makes pix_num lead the other outputs by one pixel.
module vga_timing_gen #(
   parameter int       H_DISP   = 640,
   parameter int       H_FP     = 16,
   parameter int       H_SYNC   = 96,
   parameter int       H_BP     = 48,
   parameter int       V_DISP   = 480,
   parameter int       V_FP     = 10,
   parameter int       V_SYNC   = 2,
   parameter int       V_BP     = 33,
   parameter logic     SYNC_POL = 1'b0,
   parameter int       ADDR_W   = 19
) (
   input  logic              vga_clk_i,
   input  logic              vga_rst_i,
   input  logic              pix_ce_i,
   output logic              horiz_sync,
   output logic              vert_sync,
   output logic              video_on,
   output logic [11:0]       pixel_column,
   output logic [11:0]       pixel_row,
   output logic [ADDR_W-1:0] pix_num,
   output logic              frame_start
);

   localparam logic [11:0] H_MAX = 12'(H_DISP + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_MAX = 12'(V_DISP + V_FP + V_SYNC + V_BP - 1);
   localparam logic [11:0] H_VIS = 12'(H_DISP);
   localparam logic [11:0] V_VIS = 12'(V_DISP);
   localparam logic [11:0] H_SS  = 12'(H_DISP + H_FP);
   localparam logic [11:0] H_SE  = 12'(H_DISP + H_FP + H_SYNC);
   localparam logic [11:0] V_SS  = 12'(V_DISP + V_FP);
   localparam logic [11:0] V_SE  = 12'(V_DISP + V_FP + V_SYNC);

   logic [11:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [11:0]       addr_h, addr_v;
   logic [ADDR_W-1:0] pix_num_q, pix_num_d;
   logic              hsync_q, vsync_q, video_on_q, frame_start_q;
   logic [11:0]       col_q, row_q;

   always_comb begin
      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_MAX) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_MAX) ? 12'd0 : v_cnt_q + 12'd1;
      end
   end

   // The address tracks either the pixel being presented or, when prefetching, the one after it.
`ifdef VGA_TIMING_PREFETCH_EN
   assign addr_h = h_cnt_d;
   assign addr_v = v_cnt_d;
`else
   assign addr_h = h_cnt_q;
   assign addr_v = v_cnt_q;
`endif

   always_comb begin
      pix_num_d = pix_num_q;
      if (addr_h == 12'd0 && addr_v == 12'd0) begin
         pix_num_d = '0;
      end else if (addr_h < H_VIS && addr_v < V_VIS) begin
         pix_num_d = pix_num_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge vga_clk_i) begin
      if (!vga_rst_i) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         col_q         <= '0;
         row_q         <= '0;
         pix_num_q     <= '0;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
      end else if (pix_ce_i) begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         col_q         <= h_cnt_q;
         row_q         <= v_cnt_q;
         pix_num_q     <= pix_num_d;
         video_on_q    <= (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
         frame_start_q <= (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
         hsync_q       <= (h_cnt_q >= H_SS && h_cnt_q < H_SE) ? SYNC_POL : ~SYNC_POL;
         vsync_q       <= (v_cnt_q >= V_SS && v_cnt_q < V_SE) ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign horiz_sync   = hsync_q;
   assign vert_sync    = vsync_q;
   assign video_on     = video_on_q;
   assign pixel_column = col_q;
   assign pixel_row    = row_q;
   assign pix_num      = pix_num_q;
   assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for line checks and a tiny-timing
// instance for whole-frame, clock-enable, mid-frame reset and randomized checks.
module tb_vga_timing_gen;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        von;
      logic        fs;
      logic [11:0] col;
      logic [11:0] row;
      logic [18:0] pix;
   } outs_t;

   localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
   localparam int BVD = 6, BVF = 1, BVS = 2, BVB = 1;
   localparam int BFRAME = (BHD + BHF + BHS + BHB) * (BVD + BVF + BVS + BVB);

   logic clk = 1'b0;
   logic rstA = 1'b0, ceA = 1'b1, rstB = 1'b0, ceB = 1'b1;
   logic hsA, vsA, vonA, fsA, hsB, vsB, vonB, fsB;
   logic [11:0] colA, rowA, colB, rowB;
   logic [18:0] pixA;
   logic [7:0]  pixB;
   outs_t actA, actB;
   int nA = 0, nB = 0, tickNo = 0;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   vga_timing_gen dutA (
      .vga_clk_i(clk), .vga_rst_i(rstA), .pix_ce_i(ceA),
      .horiz_sync(hsA), .vert_sync(vsA), .video_on(vonA),
      .pixel_column(colA), .pixel_row(rowA), .pix_num(pixA), .frame_start(fsA));

   vga_timing_gen #(
      .H_DISP(BHD), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
      .V_DISP(BVD), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
      .SYNC_POL(1'b1), .ADDR_W(8)
   ) dutB (
      .vga_clk_i(clk), .vga_rst_i(rstB), .pix_ce_i(ceB),
      .horiz_sync(hsB), .vert_sync(vsB), .video_on(vonB),
      .pixel_column(colB), .pixel_row(rowB), .pix_num(pixB), .frame_start(fsB));

   assign actA = {hsA, vsA, vonA, fsA, colA, rowA, pixA};
   assign actB = {hsB, vsB, vonB, fsB, colB, rowB, 11'd0, pixB};

   // Frame-buffer address shown at a raster position: last visible pixel at or before it.
   function automatic int addrOf(int c, int r, int hd, int vd);
      if (r >= vd) return hd * vd - 1;
      if (c >= hd) return r * hd + hd - 1;
      return r * hd + c;
   endfunction

   // Expected outputs after n enabled edges since reset (n = 0 means reset state).
   function automatic outs_t model(int n, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb, logic pol);
      outs_t o;
      int ht, vt, c, r, nc, nr;
      ht = hd + hf + hsw + hb;
      vt = vd + vf + vsw + vb;
      o = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      if (n > 0) begin
         c  = (n - 1) % ht;
         r  = ((n - 1) / ht) % vt;
         nc = n % ht;
         nr = (n / ht) % vt;
         o.col = 12'(c);
         o.row = 12'(r);
         o.von = (c < hd) && (r < vd);
         o.fs  = (c == 0) && (r == 0);
         o.hs  = (c >= hd + hf && c < hd + hf + hsw) ? pol : ~pol;
         o.vs  = (r >= vd + vf && r < vd + vf + vsw) ? pol : ~pol;
`ifdef VGA_TIMING_PREFETCH_EN
         o.pix = 19'(addrOf(nc, nr, hd, vd));
`else
         o.pix = 19'(addrOf(c, r, hd, vd));
`endif
      end
      return o;
   endfunction

   function automatic outs_t modelA(int n);
      return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic outs_t modelB(int n);
      return model(n, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB, 1'b1);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rstA) nA = 0; else if (ceA) nA++;
      if (!rstB) nB = 0; else if (ceB) nB++;
      tickNo++;
      #1;
   endtask

   task automatic test_reset();
      outs_t expA, expB;
      rstA = 1'b0; ceA = 1'b1; rstB = 1'b0; ceB = 1'b1;
      repeat (3) tick();
      expA = modelA(0);
      expB = modelB(0);
      checks++;
      if (actA !== expA) begin errors++; $display("FAIL reset_a got=%h exp=%h", actA, expA); end
      checks++;
      if (actB !== expB) begin errors++; $display("FAIL reset_b got=%h exp=%h", actB, expB); end
      rstA = 1'b1; rstB = 1'b1;
      tick();
      expA = modelA(nA);
      checks++;
      if (actA !== expA) begin errors++; $display("FAIL first_edge_a got=%h exp=%h", actA, expA); end
      checks++;
      if ({vonA, fsA, colA, rowA} !== {1'b1, 1'b1, 12'd0, 12'd0}) begin
         errors++; $display("FAIL first_edge_flags got=%h exp=%h", {vonA, fsA, colA, rowA}, {1'b1, 1'b1, 24'd0});
      end
   endtask

   task automatic test_line();
      outs_t exp;
      int visCnt, syncCnt, prevCol, prevRow;
      bit wrapSeen;
      visCnt  = (rowA == 12'd0 && vonA) ? 1 : 0;
      syncCnt = (rowA == 12'd0 && !hsA) ? 1 : 0;
      wrapSeen = 1'b0;
      ceA = 1'b1;
      for (int i = 0; i < 820; i++) begin
         prevCol = int'(colA);
         prevRow = int'(rowA);
         tick();
         exp = modelA(nA);
         checks++;
         if (actA !== exp) begin errors++; $display("FAIL line_a t=%0d got=%h exp=%h", tickNo, actA, exp); end
         if (rowA == 12'd0 && vonA) visCnt++;
         if (rowA == 12'd0 && !hsA) syncCnt++;
         if (prevCol == 799 && prevRow == 0) begin
            wrapSeen = 1'b1;
            checks++;
            if ({colA, rowA} !== {12'd0, 12'd1}) begin
               errors++; $display("FAIL line_wrap got=%h exp=%h", {colA, rowA}, {12'd0, 12'd1});
            end
         end
      end
      checks++;
      if (visCnt != 640) begin errors++; $display("FAIL line_visible got=%0d exp=640", visCnt); end
      checks++;
      if (syncCnt != 96) begin errors++; $display("FAIL line_hsync got=%0d exp=96", syncCnt); end
      checks++;
      if (!wrapSeen) begin errors++; $display("FAIL line_wrap_seen got=0 exp=1"); end
   endtask

   task automatic test_frame();
      outs_t exp;
      int lastFs, pulses;
      rstB = 1'b0; ceB = 1'b1;
      tick();
      rstB = 1'b1;
      lastFs = -1;
      pulses = 0;
      for (int i = 0; i < 2 * BFRAME + 20; i++) begin
         tick();
         exp = modelB(nB);
         checks++;
         if (actB !== exp) begin errors++; $display("FAIL frame_b t=%0d got=%h exp=%h", tickNo, actB, exp); end
         if (fsB) begin
            pulses++;
            if (lastFs >= 0) begin
               checks++;
               if (tickNo - lastFs != BFRAME) begin
                  errors++; $display("FAIL frame_period got=%0d exp=%0d", tickNo - lastFs, BFRAME);
               end
            end
            lastFs = tickNo;
         end
         if (colB == 12'(BHD - 1) && rowB == 12'(BVD - 1)) begin
            checks++;
            if (pixB !== 8'(BHD * BVD - 1)) begin
               errors++; $display("FAIL frame_last_pix got=%0d exp=%0d", pixB, BHD * BVD - 1);
            end
         end
      end
      checks++;
      if (pulses != 3) begin errors++; $display("FAIL frame_pulses got=%0d exp=3", pulses); end
   endtask

   task automatic test_ce_pattern();
      outs_t exp, prev;
      rstB = 1'b0;
      tick();
      rstB = 1'b1;
      for (int i = 0; i < 240; i++) begin
         ceB = (i % 4 == 0);
         prev = actB;
         tick();
         if (!ceB) begin
            checks++;
            if (actB !== prev) begin errors++; $display("FAIL ce_frozen t=%0d got=%h exp=%h", tickNo, actB, prev); end
         end
         exp = modelB(nB);
         checks++;
         if (actB !== exp) begin errors++; $display("FAIL ce_seq t=%0d got=%h exp=%h", tickNo, actB, exp); end
      end
      ceB = 1'b1;
   endtask

   task automatic test_mid_reset();
      outs_t exp;
      bit found;
      found = 1'b0;
      ceB = 1'b1;
      for (int i = 0; i < 2 * BFRAME && !found; i++) begin
         tick();
         if (colB == 12'd4 && rowB == 12'd3) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midrst_reach got=0 exp=1"); end
      rstB = 1'b0;
      tick();
      exp = modelB(0);
      checks++;
      if (actB !== exp) begin errors++; $display("FAIL midrst_reset got=%h exp=%h", actB, exp); end
      rstB = 1'b1;
      tick();
      exp = modelB(nB);
      checks++;
      if (actB !== exp) begin errors++; $display("FAIL midrst_restart got=%h exp=%h", actB, exp); end
      checks++;
      if ({fsB, colB, rowB} !== {1'b1, 24'd0}) begin
         errors++; $display("FAIL midrst_origin got=%h exp=%h", {fsB, colB, rowB}, {1'b1, 24'd0});
      end
   endtask

   task automatic test_random();
      outs_t exp;
      for (int i = 0; i < 3000; i++) begin
         ceB  = 1'($urandom_range(0, 1));
         rstB = ($urandom_range(0, 299) != 0);
         tick();
         exp = modelB(nB);
         checks++;
         if (actB !== exp) begin errors++; $display("FAIL random_b t=%0d got=%h exp=%h", tickNo, actB, exp); end
      end
      rstB = 1'b1;
      ceB  = 1'b1;
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_ce_pattern();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
